// File: rtl/watch_pkg.sv
// Shared types and helpers for the digital watch.
// State encoding, digit constants, digit packing and 12h mapping.
package watch_pkg;

    typedef enum logic [2:0] {
        RUN         = 3'd0,
        SET_HOURS   = 3'd1,
        SET_MINUTES = 3'd2,
        SET_SECONDS = 3'd3,
        SET_ALARM_H = 3'd4,
        SET_ALARM_M = 3'd5
    } state_t;

    localparam logic [5:0] DIGIT_BLANK = 6'b000001;
    localparam logic [5:0] DIGIT_SEP   = 6'b000001;

    // {en, bcd, dp_n}; the decimal point is always off.
    function automatic logic [5:0] pack_digit(
        input logic       en,
        input logic [3:0] val
    );
        return {en, val, 1'b1};
    endfunction

    // 0 shows as 12; 13..23 fold down to 1..11.
    function automatic logic [4:0] to_12h(input logic [4:0] hours);
        if (hours == 5'd0)
            return 5'd12;
        else if (hours > 5'd12)
            return hours - 5'd12;
        else
            return hours;
    endfunction

    function automatic logic [3:0] tens(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] ones(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

endpackage

// File: rtl/digital_watch_if.sv
// Button inputs and display outputs of the digital watch.
// master: button/format source; slave: the watch itself.
interface digital_watch_if;
    logic       mode_button;
    logic       add_button;
    logic       sub_button;
    logic       fmt_12h;
    logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
    logic       pm;
    logic       alarm;

    modport master (
        output mode_button, add_button, sub_button, fmt_12h,
        input  d1, d2, d3, d4, d5, d6, d7, d8, pm, alarm
    );

    modport slave (
        input  mode_button, add_button, sub_button, fmt_12h,
        output d1, d2, d3, d4, d5, d6, d7, d8, pm, alarm
    );
endinterface

// File: rtl/digital_watch_tick_gen.sv
// 1 Hz strobe and blink-phase generator.
// Ports: clock, reset (sync, active-low) -> tick_1hz, blink.
module tick_gen #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int BLINK_HZ = 2
) (
    input  logic clock,
    input  logic reset,
    output logic tick_1hz,
    output logic blink
);

    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt;
    logic [BW-1:0] bcnt;
    logic          bwrap;

    assign tick_1hz = (cnt == CW'(CLK_HZ - 1));
    assign bwrap    = (bcnt == BW'(HALF - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt   <= '0;
            bcnt  <= '0;
            blink <= 1'b0;
        end else begin
            cnt  <= tick_1hz ? '0 : cnt + CW'(1);
            bcnt <= bwrap ? '0 : bcnt + BW'(1);
            if (bwrap)
                blink <= ~blink;
        end
    end

endmodule

// File: rtl/digital_watch.sv
// Digital watch: time keeping, edit FSM, alarm, display registers.
// Ports: clock, reset (sync, active-low), bus (digital_watch_if.slave).
module digital_watch
    import watch_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BLINK_HZ   = 2,
    parameter int ALARM_SECS = 60
) (
    input logic            clock,
    input logic            reset,
    digital_watch_if.slave bus
);

    localparam int RW = $clog2(ALARM_SECS + 1);

    state_t        state, state_nxt;
    logic          tick, blink;
    logic [4:0]    hh, al_h, nh, show_h, disp_h;
    logic [5:0]    mm, ss, al_m, nm, show_m;
    logic          ring, ack, edit, trig, al_view;
    logic          en_h, en_m, en_s;
    logic [RW-1:0] rcnt;

    tick_gen #(
        .CLK_HZ   (CLK_HZ),
        .BLINK_HZ (BLINK_HZ)
    ) u_tick (
        .clock    (clock),
        .reset    (reset),
        .tick_1hz (tick),
        .blink    (blink)
    );

    function automatic logic [5:0] step(
        input logic [5:0] v,
        input logic [5:0] top,
        input logic       inc
    );
        if (inc)
            return (v == top) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? top : v - 6'd1;
    endfunction

    // A button pressed while ringing only silences the alarm.
    always_comb begin
        ack  = ring & (bus.mode_button | bus.add_button
                     | bus.sub_button);
        edit = !bus.mode_button && !ack
             && (bus.add_button || bus.sub_button);
        nm   = (mm == 6'd59) ? 6'd0 : mm + 6'd1;
        nh   = hh;
        if (mm == 6'd59)
            nh = (hh == 5'd23) ? 5'd0 : hh + 5'd1;
        trig = (state == RUN) && tick && (ss == 6'd59)
             && (nm == al_m) && (nh == al_h);
    end

    always_comb begin
        state_nxt = state;
        if (bus.mode_button && !ack) begin
            unique case (state)
                RUN:         state_nxt = SET_HOURS;
                SET_HOURS:   state_nxt = SET_MINUTES;
                SET_MINUTES: state_nxt = SET_SECONDS;
                SET_SECONDS: state_nxt = SET_ALARM_H;
                SET_ALARM_H: state_nxt = SET_ALARM_M;
                default:     state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // Ticks outside RUN are dropped rather than accumulated.
    always_ff @(posedge clock) begin
        if (!reset) begin
            hh   <= '0;
            mm   <= '0;
            ss   <= '0;
            al_h <= '0;
            al_m <= '0;
        end else if (state == RUN) begin
            if (tick) begin
                if (ss == 6'd59) begin
                    ss <= '0;
                    mm <= nm;
                    hh <= nh;
                end else begin
                    ss <= ss + 6'd1;
                end
            end
        end else if (edit) begin
            unique case (state)
                SET_HOURS:
                    hh <= 5'(step({1'b0, hh}, 6'd23, bus.add_button));
                SET_MINUTES:
                    mm <= step(mm, 6'd59, bus.add_button);
                SET_SECONDS:
                    ss <= step(ss, 6'd59, bus.add_button);
                SET_ALARM_H:
                    al_h <= 5'(step({1'b0, al_h}, 6'd23, bus.add_button));
                default:
                    al_m <= step(al_m, 6'd59, bus.add_button);
            endcase
        end
    end

    // rcnt counts ticks since the ring started.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ring <= 1'b0;
            rcnt <= '0;
        end else if (trig) begin
            ring <= 1'b1;
            rcnt <= '0;
        end else if (ack || state_nxt != RUN) begin
            ring <= 1'b0;
        end else if (ring && tick) begin
            if (rcnt == RW'(ALARM_SECS - 1))
                ring <= 1'b0;
            rcnt <= rcnt + RW'(1);
        end
    end

    always_comb begin
        al_view = (state == SET_ALARM_H) || (state == SET_ALARM_M);
        show_h  = al_view ? al_h : hh;
        show_m  = al_view ? al_m : mm;
        disp_h  = bus.fmt_12h ? to_12h(show_h) : show_h;
        en_h    = (state == SET_HOURS || state == SET_ALARM_H)
                ? blink : 1'b1;
        en_m    = (state == SET_MINUTES || state == SET_ALARM_M)
                ? blink : 1'b1;
        en_s    = (state == SET_SECONDS) ? blink : !al_view;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            bus.d8    <= DIGIT_BLANK;
            bus.d7    <= DIGIT_BLANK;
            bus.d6    <= DIGIT_BLANK;
            bus.d5    <= DIGIT_BLANK;
            bus.d4    <= DIGIT_BLANK;
            bus.d3    <= DIGIT_BLANK;
            bus.d2    <= DIGIT_BLANK;
            bus.d1    <= DIGIT_BLANK;
            bus.pm    <= 1'b0;
            bus.alarm <= 1'b0;
        end else begin
            bus.d8    <= pack_digit(en_h, tens({1'b0, disp_h}));
            bus.d7    <= pack_digit(en_h, ones({1'b0, disp_h}));
            bus.d6    <= DIGIT_SEP;
            bus.d5    <= pack_digit(en_m, tens(show_m));
            bus.d4    <= pack_digit(en_m, ones(show_m));
            bus.d3    <= DIGIT_SEP;
            bus.d2    <= pack_digit(en_s, tens(ss));
            bus.d1    <= pack_digit(en_s, ones(ss));
            bus.pm    <= bus.fmt_12h && (show_h >= 5'd12);
            bus.alarm <= ring;
        end
    end

endmodule

// File: tb/tb_digital_watch.sv
// Scoreboard bench for digital_watch against a seconds-of-day model.
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_digital_watch;

    logic clock;
    logic reset;

    digital_watch_if bus ();

    digital_watch #(
        .CLK_HZ     (10),
        .BLINK_HZ   (1),
        .ALARM_SECS (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state: time as seconds of day, alarm as minute
    // of day, mode as index 0=run 1=h 2=m 3=s 4=alarm h 5=alarm m.
    int  t, al, md, left, cyc;
    bit  ring;
    int  checks = 0;
    int  fails  = 0;
    int  ncyc   = 0;

    logic [49:0] exp_q[$];

    function automatic logic [5:0] dg(bit en, int v);
        logic [5:0] r;
        r = {en, 4'(v), 1'b1};
        return r;
    endfunction

    task automatic model_edge(input bit m, input bit a, input bit s,
                              input bit f, input bit r,
                              output logic [49:0] e);
        int sh, sm, se, dh, h, mi, dlt, md_pre;
        bit bl, eh, em, es, tick, ack, trig;
        if (!r) begin
            e = {{8{6'b000001}}, 2'b00};
            t = 0; al = 0; md = 0; ring = 0; left = 0; cyc = 0;
        end else begin
            sh = (md >= 4) ? al / 60 : t / 3600;
            sm = (md >= 4) ? al % 60 : (t / 60) % 60;
            se = t % 60;
            dh = f ? ((sh % 12 == 0) ? 12 : sh % 12) : sh;
            bl = ((cyc / 5) % 2) == 1;
            eh = (md == 1 || md == 4) ? bl : 1'b1;
            em = (md == 2 || md == 5) ? bl : 1'b1;
            es = (md == 3) ? bl : (md >= 4 ? 1'b0 : 1'b1);
            e = {dg(eh, dh / 10), dg(eh, dh % 10), 6'b000001,
                 dg(em, sm / 10), dg(em, sm % 10), 6'b000001,
                 dg(es, se / 10), dg(es, se % 10),
                 f && sh >= 12, ring};
            cyc++;
            tick = (cyc % 10) == 0;
            md_pre = md;
            ack = ring && (m || a || s);
            if (!ack && m) begin
                md = (md + 1) % 6;
            end else if (!ack && (a || s) && md_pre != 0) begin
                dlt = a ? 1 : -1;
                h = t / 3600; mi = (t / 60) % 60; se = t % 60;
                case (md_pre)
                    1: h  = (h + dlt + 24) % 24;
                    2: mi = (mi + dlt + 60) % 60;
                    3: se = (se + dlt + 60) % 60;
                    4: al = ((al / 60 + dlt + 24) % 24) * 60 + al % 60;
                    default: al = (al / 60) * 60 + (al % 60 + dlt + 60) % 60;
                endcase
                t = h * 3600 + mi * 60 + se;
            end
            trig = 0;
            if (md_pre == 0 && tick) begin
                t = (t + 1) % 86400;
                trig = (t % 60 == 0) && (t / 60 == al);
            end
            if (trig) begin
                ring = 1; left = 3;
            end else if (ack || md != 0) begin
                ring = 0;
            end else if (ring && tick) begin
                left--;
                if (left == 0) ring = 0;
            end
        end
    endtask

    task automatic step(input bit m, input bit a, input bit s,
                        input bit f, input bit r);
        logic [49:0] e;
        @(negedge clock);
        #1;
        bus.mode_button = m;
        bus.add_button  = a;
        bus.sub_button  = s;
        bus.fmt_12h     = f;
        reset           = r;
        model_edge(m, a, s, f, r, e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit f);
        repeat (n) step(0, 0, 0, f, 1);
    endtask

    task automatic press(input bit m, input bit a, input bit s);
        step(m, a, s, 0, 1);
    endtask

    // Alarm 00:01, time 00:00:59, back in RUN.
    task automatic alarm_setup();
        step(0, 0, 0, 0, 0);
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0); press(1, 0, 0);
        press(0, 1, 0);
        press(1, 0, 0);
    endtask

    always @(negedge clock) begin
        logic [49:0] e, act;
        ncyc++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            act = {bus.d8, bus.d7, bus.d6, bus.d5, bus.d4, bus.d3,
                   bus.d2, bus.d1, bus.pm, bus.alarm};
            checks++;
            if (act !== e) begin
                fails++;
                if (fails <= 40)
                    $display("FAIL outputs cycle=%0d got=%h expected=%h",
                             ncyc, act, e);
            end
        end
    end

    initial begin
        bit m, a, s, f, r;
        bus.mode_button = 0;
        bus.add_button  = 0;
        bus.sub_button  = 0;
        bus.fmt_12h     = 0;
        reset           = 0;

        // reset, free running
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        idle(25, 0);

        // rollover from 23:59:58
        step(0, 0, 0, 0, 0);
        press(1, 0, 0); press(0, 0, 1);
        press(1, 0, 0); press(0, 0, 1);
        press(1, 0, 0); press(0, 0, 1); press(0, 0, 1);
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        idle(30, 0);

        // 12-hour mapping: 00:xx then 13:05
        idle(8, 1);
        step(0, 0, 0, 1, 0);
        press(1, 0, 0);
        repeat (13) press(0, 1, 0);
        press(1, 0, 0);
        repeat (5) press(0, 1, 0);
        repeat (4) press(1, 0, 0);
        idle(12, 1);
        idle(4, 0);

        // edit wrap and priority in SET_MINUTES
        step(0, 0, 0, 0, 0);
        press(1, 0, 0); press(1, 0, 0);
        press(0, 0, 1);
        press(0, 1, 1);
        press(1, 1, 0);
        idle(3, 0);
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        idle(4, 0);

        // pause during edit at 10:00:05
        step(0, 0, 0, 0, 0);
        press(1, 0, 0);
        repeat (10) press(0, 1, 0);
        repeat (5) press(1, 0, 0);
        idle(50, 0);
        press(1, 0, 0);
        idle(50, 0);
        repeat (5) press(1, 0, 0);
        idle(15, 0);

        // alarm timeout path
        alarm_setup();
        idle(50, 0);

        // alarm acknowledge path
        alarm_setup();
        idle(15, 0);
        press(0, 1, 0);
        idle(15, 0);

        // reset mid-ring
        alarm_setup();
        idle(15, 0);
        step(0, 0, 0, 0, 0);
        idle(15, 0);

        // randomized traffic
        f = 0;
        for (int i = 0; i < 1500; i++) begin
            m = ($urandom_range(0, 19) == 0);
            a = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) f = ~f;
            r = !($urandom_range(0, 499) == 0);
            step(m, a, s, f, r);
        end
        idle(3, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            @(negedge clock);
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain left=%0d required=0", exp_q.size());
        end
        #2;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
